// File: rtl/benes_cfg_loader.sv
// Serial loader for the Benes network's per-stage switch settings: gathers words in shadow storage
// and commits them to switch_set in one edge. Define BENES_CFG_PARITY_EN to add the cfg_par even-parity check.
module benes_cfg_loader #(
  parameter int SIZE       = 32,
  parameter int LAYER_NUM  = $clog2(SIZE),
  parameter int STAGE_NUM  = 2*LAYER_NUM-1,
  parameter int SWITCH_NUM = SIZE/2,
  parameter int IDX_W      = $clog2(STAGE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SWITCH_NUM-1:0] cfg_bits,
  input  logic                  cfg_last,
`ifdef BENES_CFG_PARITY_EN
  input  logic                  cfg_par,
`endif
  input  logic                  commit_hold,
  output logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1],
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [IDX_W-1:0]      load_idx,
  output logic [1:0]            dbg_state
);

  // Handshake: a word moves on any cycle where cfg_valid && cfg_ready; while
  // cfg_valid is high and cfg_ready low the source keeps cfg_bits/cfg_last (and cfg_par) stable.

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGE_NUM-1);

  logic [1:0]            state;
  logic [SWITCH_NUM-1:0] shadow [0:STAGE_NUM-1];
  logic                  par_err;
  logic                  word_bad;
  logic                  cfg_bad;
  logic                  xfer;
  logic                  at_last;

  assign dbg_state = state;

  // Ready is gated by rst directly so it reads 0 for every cycle reset is held.
  assign cfg_ready = !rst && ((state == ST_IDLE) || (state == ST_LOAD));
  assign xfer      = cfg_valid && cfg_ready;
  assign at_last   = (load_idx == LAST_IDX);

`ifdef BENES_CFG_PARITY_EN
  assign word_bad = ^{cfg_bits, cfg_par};
`else
  assign word_bad = 1'b0;
`endif

  // Any bad word earlier in the configuration poisons the final decision.
  assign cfg_bad = par_err || word_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      load_idx <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      par_err  <= 1'b0;
      for (int s = 0; s < STAGE_NUM; s++) begin
        shadow[s]     <= '0;
        switch_set[s] <= '0;
      end
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (xfer) begin
            shadow[load_idx] <= cfg_bits;
            if (cfg_last && at_last && !cfg_bad) begin
              state <= ST_COMMIT;
            end else if (cfg_last || at_last) begin
              // Short, long or parity-damaged configuration.
              state <= ST_ERR;
            end else begin
              load_idx <= load_idx + 1'b1;
              par_err  <= cfg_bad;
              state    <= ST_LOAD;
            end
          end
        end
        ST_COMMIT: begin
          if (!commit_hold) begin
            for (int s = 0; s < STAGE_NUM; s++) begin
              switch_set[s] <= shadow[s];
            end
            cfg_done <= 1'b1;
            load_idx <= '0;
            par_err  <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_ERR: begin
          for (int s = 0; s < STAGE_NUM; s++) begin
            shadow[s] <= '0;
          end
          cfg_err  <= 1'b1;
          load_idx <= '0;
          par_err  <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    assert (!(cfg_done && cfg_err));
  end

endmodule
